// File: rtl/probe_conditioner_if.sv
// Bundles the probe conditioner's data-path signals.
// o_matchValid is a level qualifier with no ready: the correlator ignores
// o_match while it is low and samples it every cycle once it is high.
interface probe_conditioner_if #(
   parameter int N_PROBE   = 16,
   parameter int FILTER_W  = 4,
   parameter int STRETCH_W = 4
);
   logic [N_PROBE-1:0]   i_pin_probe;
   logic                 i_cg;
   logic [N_PROBE-1:0]   i_invert;
   logic [N_PROBE-1:0]   i_mask;
   logic [FILTER_W-1:0]  i_filterCycles;
   logic [STRETCH_W-1:0] i_stretchCycles;
   logic [N_PROBE-1:0]   o_match;
   logic                 o_matchValid;
   logic [N_PROBE-1:0]   o_rise;
   logic [N_PROBE-1:0]   o_fall;
   logic                 o_glitch;

   modport master (
      output i_pin_probe, i_cg, i_invert, i_mask, i_filterCycles, i_stretchCycles,
      input  o_match, o_matchValid, o_rise, o_fall, o_glitch
   );

   modport slave (
      input  i_pin_probe, i_cg, i_invert, i_mask, i_filterCycles, i_stretchCycles,
      output o_match, o_matchValid, o_rise, o_fall, o_glitch
   );
endinterface

// File: rtl/probe_conditioner.sv
// Turns asynchronous probe pins into clean synchronous match levels:
// synchroniser, optional invert, glitch filter, high-pulse stretcher, mask.
// Also produces accepted-edge pulses and a rejected-transition pulse.
module probe_conditioner #(
   parameter int N_PROBE   = 16,
   parameter int N_SYNC    = 2,
   parameter int FILTER_W  = 4,
   parameter int STRETCH_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   probe_conditioner_if.slave bus
);
   // Warm-up covers the synchroniser plus the longest possible filter run.
   localparam int WARM_TARGET = N_SYNC + (1 << FILTER_W);
   localparam int WARM_W      = $clog2(WARM_TARGET + 1);
   localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARM_TARGET);
   // The stretch counter holds "cycles left high, including this one", so it
   // is loaded with S+1 and needs one extra bit; a lone accepted high then
   // shows for S+1 cycles.
   localparam int SCNT_W = STRETCH_W + 1;

   logic [N_SYNC-1:0][N_PROBE-1:0]  sync_q, sync_d;
   logic [N_PROBE-1:0]              filt_q, filt_d;
   logic [N_PROBE-1:0][FILTER_W-1:0] cnt_q, cnt_d;
   logic [N_PROBE-1:0][SCNT_W-1:0]  scnt_q, scnt_d;
   logic [N_PROBE-1:0]              rise_q, rise_d;
   logic [N_PROBE-1:0]              fall_q, fall_d;
   logic                            glitch_q, glitch_d;
   logic [WARM_W-1:0]               warm_q, warm_d;
   logic                            valid_q, valid_d;

   logic [N_PROBE-1:0] s;
   logic [N_PROBE-1:0] reject;
   logic [N_PROBE-1:0] match;

   // Synchroniser chain: shifts only on enabled cycles.
   always_comb begin
      sync_d = sync_q;
      if (bus.i_cg) begin
         sync_d[0] = bus.i_pin_probe;
         for (int j = 1; j < N_SYNC; j++) begin
            sync_d[j] = sync_q[j-1];
         end
      end
   end

   // Per-probe glitch filter, stretcher and edge/glitch pulse generation.
   always_comb begin
      s        = sync_q[N_SYNC-1] ^ bus.i_invert;
      filt_d   = filt_q;
      cnt_d    = cnt_q;
      scnt_d   = scnt_q;
      rise_d   = '0;
      fall_d   = '0;
      reject   = '0;
      glitch_d = 1'b0;
      if (bus.i_cg) begin
         for (int i = 0; i < N_PROBE; i++) begin
            if (scnt_q[i] != '0) begin
               scnt_d[i] = scnt_q[i] - SCNT_W'(1);
            end
            if (s[i] == filt_q[i]) begin
               // Sample agrees again: any run in progress was a glitch.
               cnt_d[i]  = '0;
               reject[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] >= bus.i_filterCycles) begin
               // ">=" so lowering the threshold mid-run accepts at once.
               filt_d[i] = s[i];
               cnt_d[i]  = '0;
               rise_d[i] = s[i] & ~bus.i_mask[i];
               fall_d[i] = ~s[i] & ~bus.i_mask[i];
               if (s[i]) begin
                  scnt_d[i] = {1'b0, bus.i_stretchCycles} + SCNT_W'(1);
               end
            end else begin
               cnt_d[i] = cnt_q[i] + FILTER_W'(1);
            end
         end
         glitch_d = |(reject & ~bus.i_mask);
      end
   end

   // Warm-up counter saturates at its target; valid is sticky until reset.
   always_comb begin
      warm_d  = warm_q;
      valid_d = valid_q;
      if (bus.i_cg) begin
         if (warm_q != WARM_MAX) begin
            warm_d = warm_q + WARM_W'(1);
         end
         valid_d = valid_q | (warm_d == WARM_MAX);
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q   <= '0;
         filt_q   <= '0;
         cnt_q    <= '0;
         scnt_q   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         glitch_q <= 1'b0;
         warm_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         filt_q   <= filt_d;
         cnt_q    <= cnt_d;
         scnt_q   <= scnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         warm_q   <= warm_d;
         valid_q  <= valid_d;
      end
   end

   // Output level: filtered or still stretching, masked combinationally.
   always_comb begin
      match = '0;
      for (int i = 0; i < N_PROBE; i++) begin
         match[i] = (filt_q[i] | (scnt_q[i] != '0)) & ~bus.i_mask[i];
      end
   end

   assign bus.o_match      = match;
   assign bus.o_matchValid = valid_q;
   assign bus.o_rise       = rise_q;
   assign bus.o_fall       = fall_q;
   assign bus.o_glitch     = glitch_q;
endmodule

// File: tb/tb_probe_conditioner.sv
// Bench for probe_conditioner: directed scenarios plus a randomized run,
// all compared each cycle against a behavioural model.
module tb_probe_conditioner;
   localparam int N  = 16;
   localparam int NS = 2;
   localparam int FW = 4;
   localparam int SW = 4;
   localparam int WARM = NS + (1 << FW);

   logic clk;
   logic rst;
   logic [N-1:0]  pin, inv, msk;
   logic          cg;
   logic [FW-1:0] fcy;
   logic [SW-1:0] scy;

   int n_checks;
   int n_errors;

   probe_conditioner_if #(.N_PROBE(N), .FILTER_W(FW), .STRETCH_W(SW)) bus ();

   assign bus.i_pin_probe     = pin;
   assign bus.i_cg            = cg;
   assign bus.i_invert        = inv;
   assign bus.i_mask          = msk;
   assign bus.i_filterCycles  = fcy;
   assign bus.i_stretchCycles = scy;

   probe_conditioner #(.N_PROBE(N), .N_SYNC(NS), .FILTER_W(FW), .STRETCH_W(SW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural model ----------------
   // Sync delay as a queue of past pin vectors, filter as run lengths of
   // disagreeing samples, stretch as an absolute "high until" cycle number.
   logic [N-1:0] m_sync[$];
   logic [N-1:0] m_level;
   int           m_run[N];
   int           m_send[N];
   int           m_act;
   logic [N-1:0] m_rise, m_fall;
   logic         m_glitch;

   task automatic model_edge();
      logic [N-1:0] sv;
      if (rst) begin
         m_sync = {};
         for (int k = 0; k < NS; k++) m_sync.push_back('0);
         m_level  = '0;
         m_act    = 0;
         m_rise   = '0;
         m_fall   = '0;
         m_glitch = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_send[i] = 0;
         end
         return;
      end
      m_rise   = '0;
      m_fall   = '0;
      m_glitch = 1'b0;
      if (!cg) return;
      m_act++;
      sv = m_sync[NS-1] ^ inv;
      for (int i = 0; i < N; i++) begin
         if (sv[i] == m_level[i]) begin
            if (m_run[i] > 0 && !msk[i]) m_glitch = 1'b1;
            m_run[i] = 0;
         end else if (m_run[i] >= int'(fcy)) begin
            m_level[i] = sv[i];
            m_run[i]   = 0;
            if (sv[i]) begin
               m_send[i] = m_act + int'(scy) + 1;
               m_rise[i] = !msk[i];
            end else begin
               m_fall[i] = !msk[i];
            end
         end else begin
            m_run[i]++;
         end
      end
      m_sync.push_front(pin);
      void'(m_sync.pop_back());
   endtask

   function automatic logic [N-1:0] model_match();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (m_level[i] || (m_act < m_send[i])) && !msk[i];
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: model follows the edge, outputs compared mid-cycle.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("match",  32'(bus.o_match), 32'(model_match()));
      check("valid",  32'(bus.o_matchValid), 32'(m_act >= WARM));
      check("rise",   32'(bus.o_rise), 32'(m_rise));
      check("fall",   32'(bus.o_fall), 32'(m_fall));
      check("glitch", 32'(bus.o_glitch), 32'(m_glitch));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, highs, rises, glitches;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      pin = '1;
      inv = '0;
      msk = '0;
      cg  = 1'b1;
      fcy = 4'd3;
      scy = 4'd0;

      // Reset with pins high, then warm-up timing.
      repeat (3) begin
         tick();
         check("rst_match", 32'(bus.o_match), 32'd0);
         check("rst_valid", 32'(bus.o_matchValid), 32'd0);
      end
      rst = 1'b0;
      pin = '0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == WARM - 1) check("valid_early", 32'(bus.o_matchValid), 32'd0);
         if (c == WARM)     check("valid_rise", 32'(bus.o_matchValid), 32'd1);
      end

      // Latency F=3: level shows after edge k+N_SYNC+F.
      pin[0] = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!bus.o_match[0] && n < 20);
      check("lat_rise", 32'(n), 32'd6);
      check("rise_pulse", 32'(bus.o_rise[0]), 32'd1);
      pin[0] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (bus.o_match[0] && n < 20);
      check("lat_fall", 32'(n), 32'd6);
      check("fall_pulse", 32'(bus.o_fall[0]), 32'd1);
      repeat (4) tick();

      // Glitch: 3-cycle high rejected, 4-cycle high accepted.
      pin[2] = 1'b1;
      highs = 0;
      glitches = 0;
      for (int c = 0; c < 13; c++) begin
         if (c == 3) pin[2] = 1'b0;
         tick();
         highs += int'(bus.o_match[2]);
         glitches += int'(bus.o_glitch);
      end
      check("glitch_hi", 32'(highs), 32'd0);
      check("glitch_cnt", 32'(glitches), 32'd1);
      pin[2] = 1'b1;
      highs = 0;
      for (int c = 0; c < 16; c++) begin
         if (c == 4) pin[2] = 1'b0;
         tick();
         highs += int'(bus.o_match[2]);
      end
      check("accept_hi", 32'(highs), 32'd4);

      // Stretch F=0 S=9: single pulse, then a reload mid-stretch.
      fcy = 4'd0;
      scy = 4'd9;
      highs = 0;
      rises = 0;
      for (int c = 0; c < 25; c++) begin
         pin[5] = (c == 0);
         tick();
         highs += int'(bus.o_match[5]);
         rises += int'(bus.o_rise[5]);
      end
      check("stretch_hi", 32'(highs), 32'd10);
      check("stretch_rise", 32'(rises), 32'd1);
      highs = 0;
      rises = 0;
      for (int c = 0; c < 30; c++) begin
         pin[5] = (c == 0 || c == 4);
         tick();
         highs += int'(bus.o_match[5]);
         rises += int'(bus.o_rise[5]);
      end
      check("reload_hi", 32'(highs), 32'd14);
      check("reload_rise", 32'(rises), 32'd2);

      // Invert and mask.
      fcy = 4'd3;
      scy = 4'd0;
      inv[7] = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!bus.o_match[7] && n < 20);
      check("inv_lat", 32'(n), 32'd4);
      msk[7] = 1'b1;
      #1;
      check("mask_now", 32'(bus.o_match[7]), 32'd0);
      tick();
      msk[7] = 1'b0;
      inv[7] = 1'b0;
      repeat (8) tick();

      // Clock gate mid-filter delays acceptance by the gated cycles.
      pin[9] = 1'b1;
      n = 0;
      repeat (3) begin tick(); n++; end
      cg = 1'b0;
      repeat (5) begin tick(); n++; end
      cg = 1'b1;
      while (!bus.o_match[9] && n < 30) begin tick(); n++; end
      check("cg_delay", 32'(n), 32'd11);

      // Threshold lowered mid-run accepts on the next edge.
      fcy = 4'd15;
      pin[11] = 1'b1;
      repeat (12) tick();
      check("thr_hold", 32'(bus.o_match[11]), 32'd0);
      fcy = 4'd2;
      tick();
      check("thr_drop", 32'(bus.o_match[11]), 32'd1);

      // Randomized run.
      for (int c = 0; c < 3000; c++) begin
         pin ^= N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 63) == 0) inv[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) msk[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 99) == 0) fcy = FW'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) scy = SW'($urandom_range(0, 15));
         cg  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      cg  = 1'b1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
